cpu_prefetch: RTL and testbench

Parametrised instruction prefetch unit for the RV32 core: replaces the single-word fetch state with a decoupled fetcher that keeps a DEPTH-entry queue of (pc, instruction) pairs ahead of decode. It masters the instruction side of the request/ready memory bus, reading sequentially from a fetch pointer, and presents queued words to the decode/retire logic through a valid/consume handshake. A jump input flushes the queue and redirects fetching; a bus read already in flight is completed and its data discarded.

---
 rtl/cpu_prefetch.sv | 148 ++++++++++++++
 tb/tb_cpu_prefetch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_prefetch.sv
// cpu_prefetch: decoupled instruction prefetcher. It keeps a DEPTH-entry queue of
// (pc, instruction) pairs ahead of decode and fetches sequentially over a
// request/ready bus. A jump flushes the queue and redirects fetching. If a read
// is in flight when the jump arrives, that read is completed and its data dropped.
//
// Parameters: DEPTH (power of two, 2..32), RESET_VECTOR (first fetch address).
// Ports:
//   i_clock, i_reset (async, active-low)
//   bus:    o_request, o_address, i_ready, i_data
//   decode: o_valid, o_instruction, o_pc, i_consume, o_level
//   redirect: i_jump, i_jump_address
// Build option: define CPU_PREFETCH_BYPASS_EN to forward returning bus data to the
// head outputs combinationally when the queue is empty.
module cpu_prefetch #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  output logic                     o_request,
  output logic [31:0]              o_address,
  input  logic                     i_ready,
  input  logic [31:0]              i_data,
  output logic                     o_valid,
  output logic [31:0]              o_instruction,
  output logic [31:0]              o_pc,
  input  logic                     i_consume,
  input  logic                     i_jump,
  input  logic [31:0]              i_jump_address,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_DISCARD} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [31:0]        pc_mem    [DEPTH];
  logic [31:0]        instr_mem [DEPTH];

  logic issue_c, fill_c, push_c, pop_c;

  // A completed read that is not cancelled by a same-cycle jump
  assign fill_c = (state_q == S_REQUEST) && i_ready && !i_jump;
  assign pop_c  = i_consume && (level_q != '0);

`ifdef CPU_PREFETCH_BYPASS_EN
  logic bypass_c;
  // Empty queue: the returning word is presented directly. If it is consumed in
  // the same cycle, it is never written into the queue.
  assign bypass_c = fill_c && (level_q == '0);
  assign push_c   = fill_c && !(bypass_c && i_consume);

  always_comb begin
    o_valid       = (level_q != '0) || bypass_c;
    o_instruction = bypass_c ? i_data     : instr_mem[rd_ptr_q];
    o_pc          = bypass_c ? fetch_pc_q : pc_mem[rd_ptr_q];
  end
`else
  assign push_c = fill_c;

  always_comb begin
    o_valid       = (level_q != '0);
    o_instruction = instr_mem[rd_ptr_q];
    o_pc          = pc_mem[rd_ptr_q];
  end
`endif

  assign o_level = level_q;

  // Next-state logic: issue a new read only from IDLE with room in the queue
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_jump && (level_q < LVL_W'(DEPTH))) begin
          issue_c = 1'b1;
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        // A ready in the jump cycle still retires the transaction; its data is dropped
        if (i_ready)     state_d = S_IDLE;
        else if (i_jump) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and bus outputs. o_request drops for at least one cycle
  // between transactions because every transaction returns through IDLE.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      o_request <= 1'b0;
      o_address <= RESET_VECTOR;
    end else begin
      state_q   <= state_d;
      o_request <= (state_d != S_IDLE);
      if (issue_c) o_address <= fetch_pc_q;
    end
  end

  // Fetch pointer: redirected by a jump, otherwise advances on each completed read
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc_q <= RESET_VECTOR;
    end else if (i_jump) begin
      fetch_pc_q <= i_jump_address & 32'hFFFF_FFFC;
    end else if (fill_c) begin
      fetch_pc_q <= fetch_pc_q + 32'd4;
    end
  end

  // Queue storage and occupancy. A jump overrides both push and pop.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (i_jump) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) begin
        pc_mem[wr_ptr_q]    <= fetch_pc_q;
        instr_mem[wr_ptr_q] <= i_data;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    end
  end

endmodule

// File: tb/tb_cpu_prefetch.sv
// Testbench for cpu_prefetch: a bus responder with a configurable number of wait
// states returns addr ^ 32'hA5A5_0000. Each test pushes the (pc, instruction)
// pairs it expects onto a scoreboard, and every consumed head is popped from the
// scoreboard and compared with it.
module tb_cpu_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_request, o_valid;
  logic [31:0] o_address, o_instruction, o_pc;
  logic        i_ready = 1'b0;
  logic [31:0] i_data = 32'h0;
  logic        i_consume = 1'b0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_address = 32'h0;
  logic [$clog2(DEPTH):0] o_level;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   wait_states = 0;
  int   wcnt = 0;

  cpu_prefetch #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .o_request(o_request), .o_address(o_address),
    .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_instruction(o_instruction), .o_pc(o_pc),
    .i_consume(i_consume), .i_jump(i_jump), .i_jump_address(i_jump_address),
    .o_level(o_level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Bus responder: ready after wait_states idle cycles of an outstanding request
  initial begin
    forever begin
      @(negedge clk);
      if (o_request && rst_n) begin
        if (wcnt >= wait_states) begin
          i_ready = 1'b1;
          i_data  = bus_data(o_address);
          wcnt    = 0;
        end else begin
          i_ready = 1'b0;
          i_data  = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        i_ready = 1'b0;
        wcnt    = 0;
      end
    end
  end

  task automatic apply_reset(input int ws);
    rst_n = 1'b0;
    i_consume = 1'b0;
    i_jump = 1'b0;
    i_jump_address = 32'h0;
    wait_states = ws;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (o_request !== 1'b0) begin failures++; $display("FAIL reset_request got=%0h exp=0", o_request); end
    checks++; if (o_address !== RV) begin failures++; $display("FAIL reset_address got=%h exp=%h", o_address, RV); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", o_valid); end
    checks++; if (o_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", o_instruction); end
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
    checks++; if (o_level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", o_level); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_request !== 1'b1) begin failures++; $display("FAIL first_request got=%0h exp=1", o_request); end
    checks++; if (o_address !== RV) begin failures++; $display("FAIL first_address got=%h exp=%h", o_address, RV); end
  endtask

  task automatic test_latency;
    int n;
    apply_reset(0);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_request && n < 10);
    checks++; if (!o_request) begin failures++; $display("FAIL lat_request_timeout got=0 exp=1"); end
    #2;
`ifdef CPU_PREFETCH_BYPASS_EN
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%0h exp=1", o_valid); end
    checks++; if (o_instruction !== bus_data(RV)) begin failures++; $display("FAIL bypass_instr got=%h exp=%h", o_instruction, bus_data(RV)); end
    checks++; if (o_pc !== RV) begin failures++; $display("FAIL bypass_pc got=%h exp=%h", o_pc, RV); end
    i_consume = 1'b1;
    @(posedge clk); #1;
    i_consume = 1'b0;
    checks++; if (o_level !== '0) begin failures++; $display("FAIL bypass_level got=%0d exp=0", o_level); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bypass_after_valid got=%0h exp=0", o_valid); end
`else
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL lat_same_cycle_valid got=%0h exp=0", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL lat_next_valid got=%0h exp=1", o_valid); end
    checks++; if (o_pc !== RV) begin failures++; $display("FAIL lat_pc got=%h exp=%h", o_pc, RV); end
    checks++; if (o_instruction !== bus_data(RV)) begin failures++; $display("FAIL lat_instr got=%h exp=%h", o_instruction, bus_data(RV)); end
    checks++; if (o_level !== 3'd1) begin failures++; $display("FAIL lat_level got=%0d exp=1", o_level); end
`endif
  endtask

  task automatic test_fill;
    logic [31:0] addrs [8];
    int n_req, budget;
    logic prev_req;
    exp_t e;
    apply_reset(0);
    for (int i = 0; i < 4; i++) expq.push_back('{pc: RV + 32'(4 * i), instr: bus_data(RV + 32'(4 * i))});
    n_req = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_request && !prev_req) begin
        if (n_req < 8) addrs[n_req] = o_address;
        n_req++;
      end
      prev_req = o_request;
    end
    checks++; if (n_req != 4) begin failures++; $display("FAIL fill_req_count got=%0d exp=4", n_req); end
    for (int i = 0; i < 4 && i < n_req; i++) begin
      checks++; if (addrs[i] !== RV + 32'(4 * i)) begin failures++; $display("FAIL fill_addr%0d got=%h exp=%h", i, addrs[i], RV + 32'(4 * i)); end
    end
    checks++; if (o_request !== 1'b0) begin failures++; $display("FAIL fill_request_full got=%0h exp=0", o_request); end
    checks++; if (o_level !== 3'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", o_level); end
    checks++; if (o_pc !== 32'h0 || o_instruction !== 32'hA5A5_0000) begin
      failures++; $display("FAIL fill_head got=%h/%h exp=00000000/a5a50000", o_pc, o_instruction);
    end
    budget = 0;
    while (expq.size() != 0 && budget < 30) begin
      @(negedge clk); budget++;
      if (o_valid) begin
        e = expq.pop_front();
        checks++; if (o_pc !== e.pc || o_instruction !== e.instr) begin
          failures++; $display("FAIL fill_pop got=%h/%h exp=%h/%h", o_pc, o_instruction, e.pc, e.instr);
        end
        i_consume = 1'b1;
      end else i_consume = 1'b0;
    end
    i_consume = 1'b0;
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL fill_drain_timeout got=%0d exp=0 left", expq.size()); end
  endtask

  task automatic test_stream;
    int cyc, max_level;
    exp_t e;
    apply_reset(0);
    for (int i = 0; i < 12; i++) expq.push_back('{pc: RV + 32'(4 * i), instr: bus_data(RV + 32'(4 * i))});
    i_consume = 1'b1;
    cyc = 0;
    max_level = 0;
    while (expq.size() != 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (int'(o_level) > max_level) max_level = int'(o_level);
      if (o_valid) begin
        e = expq.pop_front();
        checks++; if (o_pc !== e.pc || o_instruction !== e.instr) begin
          failures++; $display("FAIL stream_pop got=%h/%h exp=%h/%h", o_pc, o_instruction, e.pc, e.instr);
        end
      end
    end
    i_consume = 1'b0;
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL stream_timeout got=%0d exp=0 left", expq.size()); end
    checks++; if (max_level > 1) begin failures++; $display("FAIL stream_max_level got=%0d exp<=1", max_level); end
    checks++; if (cyc > 28) begin failures++; $display("FAIL stream_cycles got=%0d exp<=28", cyc); end
  endtask

  task automatic test_jump;
    int n, budget;
    exp_t e;
    apply_reset(3);
    n = 0;
    do begin @(negedge clk); n++; end while (o_level != 3'd2 && n < 40);
    checks++; if (o_level !== 3'd2) begin failures++; $display("FAIL jump_prefill got=%0d exp=2", o_level); end
    n = 0;
    do begin @(negedge clk); n++; end while (!o_request && n < 10);
    checks++; if (o_address !== 32'h8) begin failures++; $display("FAIL jump_inflight_addr got=%h exp=00000008", o_address); end
    i_jump = 1'b1;
    i_jump_address = 32'h0000_1003;
    @(negedge clk);
    i_jump = 1'b0;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL jump_valid got=%0h exp=0", o_valid); end
    checks++; if (o_level !== '0) begin failures++; $display("FAIL jump_level got=%0d exp=0", o_level); end
    checks++; if (o_request !== 1'b1 || o_address !== 32'h8) begin
      failures++; $display("FAIL jump_discard_hold got=%0h/%h exp=1/00000008", o_request, o_address);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (o_request && n < 10);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_request && n < 10);
    checks++; if (o_address !== 32'h0000_1000) begin failures++; $display("FAIL jump_new_addr got=%h exp=00001000", o_address); end
    expq.push_back('{pc: 32'h1000, instr: bus_data(32'h1000)});
    expq.push_back('{pc: 32'h1004, instr: bus_data(32'h1004)});
    budget = 0;
    while (expq.size() != 0 && budget < 40) begin
      @(negedge clk); budget++;
      if (o_valid) begin
        e = expq.pop_front();
        checks++; if (o_pc !== e.pc || o_instruction !== e.instr) begin
          failures++; $display("FAIL jump_pop got=%h/%h exp=%h/%h", o_pc, o_instruction, e.pc, e.instr);
        end
        i_consume = 1'b1;
      end else i_consume = 1'b0;
    end
    i_consume = 1'b0;
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL jump_drain_timeout got=%0d exp=0 left", expq.size()); end
  endtask

  task automatic test_full;
    int n, budget, req_seen;
    exp_t e;
    apply_reset(0);
    for (int i = 0; i < 6; i++) expq.push_back('{pc: RV + 32'(4 * i), instr: bus_data(RV + 32'(4 * i))});
    n = 0;
    do begin @(negedge clk); n++; end while (o_level != 3'd4 && n < 30);
    req_seen = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (o_request) req_seen++; end
    checks++; if (req_seen != 0 || o_level !== 3'd4) begin
      failures++; $display("FAIL full_idle got=req%0d/lvl%0d exp=req0/lvl4", req_seen, o_level);
    end
    // Pop one to make room, then pop again in the same cycle as the refill completes
    e = expq.pop_front();
    checks++; if (o_pc !== e.pc || o_instruction !== e.instr) begin
      failures++; $display("FAIL full_pop0 got=%h/%h exp=%h/%h", o_pc, o_instruction, e.pc, e.instr);
    end
    i_consume = 1'b1;
    @(negedge clk);
    i_consume = 1'b0;
    n = 0;
    while (!o_request && n < 10) begin @(negedge clk); n++; end
    checks++; if (o_level !== 3'd3) begin failures++; $display("FAIL full_pre_level got=%0d exp=3", o_level); end
    e = expq.pop_front();
    checks++; if (o_pc !== e.pc || o_instruction !== e.instr) begin
      failures++; $display("FAIL full_pop1 got=%h/%h exp=%h/%h", o_pc, o_instruction, e.pc, e.instr);
    end
    i_consume = 1'b1;
    @(negedge clk);
    i_consume = 1'b0;
    checks++; if (o_level !== 3'd3) begin failures++; $display("FAIL full_push_pop_level got=%0d exp=3", o_level); end
    n = 0;
    do begin @(negedge clk); n++; end while (o_level != 3'd4 && n < 10);
    req_seen = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (o_request) req_seen++; end
    checks++; if (req_seen != 0 || o_level !== 3'd4) begin
      failures++; $display("FAIL full_hold got=req%0d/lvl%0d exp=req0/lvl4", req_seen, o_level);
    end
    budget = 0;
    while (expq.size() != 0 && budget < 30) begin
      @(negedge clk); budget++;
      if (o_valid) begin
        e = expq.pop_front();
        checks++; if (o_pc !== e.pc || o_instruction !== e.instr) begin
          failures++; $display("FAIL full_pop got=%h/%h exp=%h/%h", o_pc, o_instruction, e.pc, e.instr);
        end
        i_consume = 1'b1;
      end else i_consume = 1'b0;
    end
    i_consume = 1'b0;
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL full_drain_timeout got=%0d exp=0 left", expq.size()); end
  endtask

  task automatic test_reset_mid;
    int n;
    apply_reset(5);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_request && n < 10);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (o_request !== 1'b0) begin failures++; $display("FAIL midreset_request got=%0h exp=0", o_request); end
    checks++; if (o_address !== RV || o_level !== '0) begin
      failures++; $display("FAIL midreset_state got=%h/%0d exp=%h/0", o_address, o_level, RV);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_request !== 1'b1 || o_address !== RV) begin
      failures++; $display("FAIL midreset_restart got=%0h/%h exp=1/%h", o_request, o_address, RV);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_stream();
    test_jump();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
